// File: rtl/axi4l_mixer_reg_bank_pkg.sv
// Shared register-map indices, AXI response codes and read filler for the mixer register bank.
// Constants only; no logic, latency or backpressure of its own.
package axi4l_mixer_reg_bank_pkg;

   localparam int IDX_HW_VERSION   = 0;
   localparam int IDX_LED_0        = 1;
   localparam int IDX_IRQ_STATUS   = 2;
   localparam int IDX_IRQ_MASK     = 3;
   localparam int IDX_OUTPUT_GAIN  = 4;
   localparam int IDX_CH_GAIN_BASE = 5;

   localparam logic [31:0] BAADFACE = 32'hBAADFACE;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } axi_resp_t;

   function automatic int map_width(input int nr_ch);
      return $clog2(IDX_CH_GAIN_BASE + nr_ch);
   endfunction

endpackage

// File: rtl/axi4l_slave_if.sv
// AXI4-Lite slave handshakes with independent AW/W slots; write commits the cycle after both slots fill, B/R one cycle later.
// Slots stay occupied until the B handshake; R is held until rready, giving one read per two cycles.
module axi4l_slave_if
   import axi4l_mixer_reg_bank_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16,
   parameter int MAP_W  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_W-1:0]     awaddr,
   input  logic                  awvalid,
   output logic                  awready,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   wstrb,
   input  logic                  wvalid,
   output logic                  wready,
   output logic [1:0]            bresp,
   output logic                  bvalid,
   input  logic                  bready,
   input  logic [ADDR_W-1:0]     araddr,
   input  logic                  arvalid,
   output logic                  arready,
   output logic [DATA_W-1:0]     rdata,
   output logic [1:0]            rresp,
   output logic                  rvalid,
   input  logic                  rready,
   output logic                  wr_en,
   output logic [MAP_W-1:0]      wr_idx,
   output logic [DATA_W-1:0]     wr_data,
   output logic [DATA_W/8-1:0]   wr_strb,
   input  logic                  wr_err,
   output logic                  rd_en,
   output logic [MAP_W-1:0]      rd_idx,
   input  logic [DATA_W-1:0]     rd_data,
   input  logic                  rd_err
);

   localparam int ADDR_LSB = $clog2(DATA_W/8);

   logic                aw_full_q, aw_full_d;
   logic [MAP_W-1:0]    aw_idx_q, aw_idx_d;
   logic                w_full_q, w_full_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
   logic                awready_q, awready_d;
   logic                wready_q, wready_d;
   logic                bvalid_q, bvalid_d;
   axi_resp_t           bresp_q, bresp_d;
   logic                arready_q, arready_d;
   logic                rvalid_q, rvalid_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   axi_resp_t           rresp_q, rresp_d;

   // Only the index field of each address is decoded; the rest aliases.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{awaddr, araddr};

   assign wr_en   = aw_full_q && w_full_q && !bvalid_q;
   assign wr_idx  = aw_idx_q;
   assign wr_data = wdata_q;
   assign wr_strb = wstrb_q;
   assign rd_en   = arvalid && arready_q;
   assign rd_idx  = araddr[ADDR_LSB +: MAP_W];

   always_comb begin
      aw_full_d = aw_full_q;
      aw_idx_d  = aw_idx_q;
      w_full_d  = w_full_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;

      if (awvalid && awready_q) begin
         aw_full_d = 1'b1;
         aw_idx_d  = awaddr[ADDR_LSB +: MAP_W];
      end
      if (wvalid && wready_q) begin
         w_full_d = 1'b1;
         wdata_d  = wdata;
         wstrb_d  = wstrb;
      end
      if (wr_en) begin
         bvalid_d = 1'b1;
         bresp_d  = wr_err ? SLVERR : OKAY;
      end
      if (bvalid_q && bready) begin
         bvalid_d  = 1'b0;
         aw_full_d = 1'b0;
         w_full_d  = 1'b0;
      end

      if (rd_en) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_data;
         rresp_d  = rd_err ? SLVERR : OKAY;
      end else if (rvalid_q && rready) begin
         rvalid_d = 1'b0;
      end

      // Readies are registered so they sit low through reset and come up one cycle later.
      awready_d = !aw_full_d && !bvalid_d;
      wready_d  = !w_full_d && !bvalid_d;
      arready_d = !rvalid_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_full_q <= 1'b0;
         aw_idx_q  <= '0;
         w_full_q  <= 1'b0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= OKAY;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= OKAY;
      end else begin
         aw_full_q <= aw_full_d;
         aw_idx_q  <= aw_idx_d;
         w_full_q  <= w_full_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   assign awready = awready_q;
   assign wready  = wready_q;
   assign bvalid  = bvalid_q;
   assign bresp   = bresp_q;
   assign arready = arready_q;
   assign rvalid  = rvalid_q;
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;

endmodule

// File: rtl/axi4l_mixer_reg_bank.sv
// Mixer/LED register file with sticky maskable IRQ status; registers update on the commit edge, irq one cycle later.
// Backpressure is handled entirely in axi4l_slave_if; reads see pre-commit values.
module axi4l_mixer_reg_bank
   import axi4l_mixer_reg_bank_pkg::*;
#(
   parameter int AXI_DATA_WIDTH_P = 32,
   parameter int AXI_ADDR_WIDTH_P = 16,
   parameter int GAIN_WIDTH_P     = 24,
   parameter int Q_BITS_P         = 16,
   parameter int NR_OF_CHANNELS_P = 4,
   parameter int IRQ_WIDTH_P      = 8
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic [AXI_ADDR_WIDTH_P-1:0]              awaddr,
   input  logic                                     awvalid,
   output logic                                     awready,
   input  logic [AXI_DATA_WIDTH_P-1:0]              wdata,
   input  logic [AXI_DATA_WIDTH_P/8-1:0]            wstrb,
   input  logic                                     wvalid,
   output logic                                     wready,
   output logic [1:0]                               bresp,
   output logic                                     bvalid,
   input  logic                                     bready,
   input  logic [AXI_ADDR_WIDTH_P-1:0]              araddr,
   input  logic                                     arvalid,
   output logic                                     arready,
   output logic [AXI_DATA_WIDTH_P-1:0]              rdata,
   output logic [1:0]                               rresp,
   output logic                                     rvalid,
   input  logic                                     rready,
   input  logic [AXI_DATA_WIDTH_P-1:0]              sr_hardware_version,
   input  logic [IRQ_WIDTH_P-1:0]                   irq_set,
   output logic [AXI_DATA_WIDTH_P-1:0]              cr_led_0,
   output logic [GAIN_WIDTH_P-1:0]                  cr_mix_output_gain,
   output logic [NR_OF_CHANNELS_P*GAIN_WIDTH_P-1:0] cr_mix_channel_gain,
   output logic                                     irq
);

   localparam int DW      = AXI_DATA_WIDTH_P;
   localparam int GW      = GAIN_WIDTH_P;
   localparam int IW      = IRQ_WIDTH_P;
   localparam int NR_CH   = NR_OF_CHANNELS_P;
   localparam int MAP_W   = map_width(NR_OF_CHANNELS_P);
   localparam int NR_REGS = IDX_CH_GAIN_BASE + NR_OF_CHANNELS_P;
   localparam logic [GW-1:0] GAIN_UNITY = GW'(1) << Q_BITS_P;

   logic              wr_en, wr_err, rd_en, rd_err;
   logic [MAP_W-1:0]  wr_idx, rd_idx;
   logic [DW-1:0]     wr_data, rd_data;
   logic [DW/8-1:0]   wr_strb;
   logic [DW-1:0]     wr_keep, wr_new;

   logic [DW-1:0]     led_q, led_d;
   logic [IW-1:0]     status_q, status_d;
   logic [IW-1:0]     mask_q, mask_d;
   logic [IW-1:0]     status_clr;
   logic [GW-1:0]     out_gain_q, out_gain_d;
   logic [GW-1:0]     ch_gain_q [NR_CH];
   logic [GW-1:0]     ch_gain_d [NR_CH];
   logic              irq_q, irq_d;

   axi4l_slave_if #(
      .DATA_W (DW),
      .ADDR_W (AXI_ADDR_WIDTH_P),
      .MAP_W  (MAP_W)
   ) u_slave_if (
      .clk     (clk),
      .rst_n   (rst_n),
      .awaddr  (awaddr),
      .awvalid (awvalid),
      .awready (awready),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .wvalid  (wvalid),
      .wready  (wready),
      .bresp   (bresp),
      .bvalid  (bvalid),
      .bready  (bready),
      .araddr  (araddr),
      .arvalid (arvalid),
      .arready (arready),
      .rdata   (rdata),
      .rresp   (rresp),
      .rvalid  (rvalid),
      .rready  (rready),
      .wr_en   (wr_en),
      .wr_idx  (wr_idx),
      .wr_data (wr_data),
      .wr_strb (wr_strb),
      .wr_err  (wr_err),
      .rd_en   (rd_en),
      .rd_idx  (rd_idx),
      .rd_data (rd_data),
      .rd_err  (rd_err)
   );

   always_comb begin
      wr_keep = '1;
      for (int k = 0; k < DW/8; k++) begin
         wr_keep[k*8 +: 8] = {8{!wr_strb[k]}};
      end
      wr_new = wr_data & ~wr_keep;
      wr_err = (int'(wr_idx) == IDX_HW_VERSION) || (int'(wr_idx) >= NR_REGS);
   end

   always_comb begin
      led_d      = led_q;
      mask_d     = mask_q;
      out_gain_d = out_gain_q;
      ch_gain_d  = ch_gain_q;
      status_clr = '0;
      if (wr_en && !wr_err) begin
         case (int'(wr_idx))
            IDX_LED_0:       led_d      = (led_q & wr_keep) | wr_new;
            IDX_IRQ_STATUS:  status_clr = IW'(wr_new);
            IDX_IRQ_MASK:    mask_d     = IW'((DW'(mask_q) & wr_keep) | wr_new);
            IDX_OUTPUT_GAIN: out_gain_d = GW'((DW'(out_gain_q) & wr_keep) | wr_new);
            default: begin
               for (int n = 0; n < NR_CH; n++) begin
                  if (int'(wr_idx) == IDX_CH_GAIN_BASE + n) begin
                     ch_gain_d[n] = GW'((DW'(ch_gain_q[n]) & wr_keep) | wr_new);
                  end
               end
            end
         endcase
      end
      // A set pulse wins over a same-cycle W1C of the same bit.
      status_d = (status_q & ~status_clr) | irq_set;
      irq_d    = |(status_q & mask_q);
   end

   always_comb begin
      rd_data = '0;
      rd_err  = 1'b0;
      if (rd_en) begin
         rd_data = DW'(BAADFACE);
         rd_err  = 1'b1;
         case (int'(rd_idx))
            IDX_HW_VERSION:  begin rd_data = sr_hardware_version; rd_err = 1'b0; end
            IDX_LED_0:       begin rd_data = led_q;               rd_err = 1'b0; end
            IDX_IRQ_STATUS:  begin rd_data = DW'(status_q);       rd_err = 1'b0; end
            IDX_IRQ_MASK:    begin rd_data = DW'(mask_q);         rd_err = 1'b0; end
            IDX_OUTPUT_GAIN: begin rd_data = DW'(out_gain_q);     rd_err = 1'b0; end
            default: begin
               for (int n = 0; n < NR_CH; n++) begin
                  if (int'(rd_idx) == IDX_CH_GAIN_BASE + n) begin
                     rd_data = DW'(ch_gain_q[n]);
                     rd_err  = 1'b0;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_q      <= '0;
         status_q   <= '0;
         mask_q     <= '0;
         out_gain_q <= GAIN_UNITY;
         for (int n = 0; n < NR_CH; n++) begin
            ch_gain_q[n] <= GAIN_UNITY;
         end
         irq_q      <= 1'b0;
      end else begin
         led_q      <= led_d;
         status_q   <= status_d;
         mask_q     <= mask_d;
         out_gain_q <= out_gain_d;
         ch_gain_q  <= ch_gain_d;
         irq_q      <= irq_d;
      end
   end

   for (genvar n = 0; n < NR_CH; n++) begin : g_ch_out
      assign cr_mix_channel_gain[n*GW +: GW] = ch_gain_q[n];
   end

   assign cr_led_0           = led_q;
   assign cr_mix_output_gain = out_gain_q;
   assign irq                = irq_q;

endmodule

// File: tb/tb_axi4l_mixer_reg_bank.sv
// Directed bench for axi4l_mixer_reg_bank: split AW/W, error map, W1C IRQ, read hold, backpressure, mid-transaction reset.
module tb_axi4l_mixer_reg_bank;

   localparam logic [31:0] HW_VER = 32'h0102_0304;
   localparam logic [23:0] UNITY  = 24'h010000;

   logic        clk, rst_n;
   logic [15:0] awaddr, araddr;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic [31:0] sr_hardware_version;
   logic [7:0]  irq_set;
   logic [31:0] cr_led_0;
   logic [23:0] cr_mix_output_gain;
   logic [95:0] cr_mix_channel_gain;
   logic        irq;

   int   checks = 0;
   int   errors = 0;
   logic irq_at_b;

   axi4l_mixer_reg_bank #(
      .AXI_DATA_WIDTH_P (32),
      .AXI_ADDR_WIDTH_P (16),
      .GAIN_WIDTH_P     (24),
      .Q_BITS_P         (16),
      .NR_OF_CHANNELS_P (4),
      .IRQ_WIDTH_P      (8)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .awaddr              (awaddr),
      .awvalid             (awvalid),
      .awready             (awready),
      .wdata               (wdata),
      .wstrb               (wstrb),
      .wvalid              (wvalid),
      .wready              (wready),
      .bresp               (bresp),
      .bvalid              (bvalid),
      .bready              (bready),
      .araddr              (araddr),
      .arvalid             (arvalid),
      .arready             (arready),
      .rdata               (rdata),
      .rresp               (rresp),
      .rvalid              (rvalid),
      .rready              (rready),
      .sr_hardware_version (sr_hardware_version),
      .irq_set             (irq_set),
      .cr_led_0            (cr_led_0),
      .cr_mix_output_gain  (cr_mix_output_gain),
      .cr_mix_channel_gain (cr_mix_channel_gain),
      .irq                 (irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic axi_write(input int idx, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp);
      bit   done;
      int   cyc;
      logic hs_aw, hs_w;
      done = 0; cyc = 0; resp = 2'bxx;
      awaddr = 16'(idx * 4); awvalid = 1'b1;
      wdata = data; wstrb = strb; wvalid = 1'b1; bready = 1'b1;
      while (!done && cyc < 100) begin
         @(negedge clk);
         hs_aw = awvalid && awready;
         hs_w  = wvalid && wready;
         if (bvalid && bready) begin
            done = 1; resp = bresp; irq_at_b = irq;
         end
         @(posedge clk); #1;
         if (hs_aw) awvalid = 1'b0;
         if (hs_w)  wvalid = 1'b0;
         cyc++;
      end
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
      if (!done) begin
         checks++; errors++;
         $display("FAIL write_timeout idx %0d: got no bvalid, required bvalid within 100 cycles", idx);
      end
   endtask

   task automatic axi_read(input int idx, output logic [31:0] data, output logic [1:0] resp);
      bit   done;
      int   cyc;
      logic hs;
      done = 0; cyc = 0; data = 'x; resp = 2'bxx;
      araddr = 16'(idx * 4); arvalid = 1'b1; rready = 1'b1;
      while (!done && cyc < 100) begin
         @(negedge clk);
         hs = arvalid && arready;
         if (rvalid && rready) begin
            done = 1; data = rdata; resp = rresp;
         end
         @(posedge clk); #1;
         if (hs) arvalid = 1'b0;
         cyc++;
      end
      arvalid = 1'b0; rready = 1'b0;
      if (!done) begin
         checks++; errors++;
         $display("FAIL read_timeout idx %0d: got no rvalid, required rvalid within 100 cycles", idx);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
      araddr = '0; arvalid = 0; rready = 0; sr_hardware_version = HW_VER; irq_set = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({awready, wready, bvalid, arready, rvalid, irq} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got aw/w/b/ar/r/irq %b, required 000000",
                  {awready, wready, bvalid, arready, rvalid, irq});
      end
      checks++;
      if ({bresp, rresp, rdata} !== 36'h0) begin
         errors++;
         $display("FAIL reset_resp_data: got bresp %b rresp %b rdata %h, required 0", bresp, rresp, rdata);
      end
      checks++;
      if (cr_mix_output_gain !== UNITY || cr_mix_channel_gain !== {4{UNITY}} || cr_led_0 !== 32'h0) begin
         errors++;
         $display("FAIL reset_regs: got out %h ch %h led %h, required out 010000 ch all 010000 led 0",
                  cr_mix_output_gain, cr_mix_channel_gain, cr_led_0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({awready, wready, arready} !== 3'b111) begin
         errors++;
         $display("FAIL ready_after_reset: got aw/w/ar %b, required 111", {awready, wready, arready});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_split_write();
      int          bcount;
      logic        w_blocked_ok;
      logic [1:0]  resp;
      logic [31:0] d;
      logic [1:0]  r;
      bcount = 0; w_blocked_ok = 1'b1; resp = 2'bxx;
      wdata = 32'h00AB_CDEF; wstrb = 4'b0011; wvalid = 1'b1; awaddr = 16'(6 * 4); bready = 1'b1;
      @(negedge clk);
      checks++;
      if (wready !== 1'b1) begin
         errors++; $display("FAIL split_w_accept: got wready %b, required 1", wready);
      end
      @(posedge clk); #1;
      wvalid = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (bvalid) bcount++;
         if (wready !== 1'b0) w_blocked_ok = 1'b0;
         @(posedge clk); #1;
      end
      checks++;
      if (w_blocked_ok !== 1'b1) begin
         errors++; $display("FAIL split_w_slot_full: got wready high while W slot held, required 0");
      end
      awvalid = 1'b1;
      @(negedge clk);
      checks++;
      if (awready !== 1'b1) begin
         errors++; $display("FAIL split_aw_accept: got awready %b, required 1", awready);
      end
      @(posedge clk); #1;
      awvalid = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (bvalid) begin bcount++; resp = bresp; end
         @(posedge clk); #1;
      end
      bready = 1'b0;
      checks++;
      if (bcount !== 1 || resp !== 2'b00) begin
         errors++; $display("FAIL split_bresp: got %0d bvalid cycles resp %b, required 1 cycle resp 00", bcount, resp);
      end
      checks++;
      if (cr_mix_channel_gain[24 +: 24] !== 24'h01CDEF || cr_mix_channel_gain[0 +: 24] !== UNITY) begin
         errors++; $display("FAIL split_gain: got ch1 %h ch0 %h, required 01cdef 010000",
                            cr_mix_channel_gain[24 +: 24], cr_mix_channel_gain[0 +: 24]);
      end
      axi_read(6, d, r);
      checks++;
      if (d !== 32'h0001_CDEF || r !== 2'b00) begin
         errors++; $display("FAIL split_readback: got %h/%b, required 0001cdef/00", d, r);
      end
   endtask

   task automatic test_error_map();
      logic [1:0]  resp, r;
      logic [31:0] d;
      axi_write(0, 32'hFFFF_FFFF, 4'hF, resp);
      checks++;
      if (resp !== 2'b10) begin
         errors++; $display("FAIL ro_write_bresp: got %b, required 10", resp);
      end
      axi_read(0, d, r);
      checks++;
      if (d !== HW_VER || r !== 2'b00) begin
         errors++; $display("FAIL hw_version_read: got %h/%b, required 01020304/00", d, r);
      end
      axi_read(9, d, r);
      checks++;
      if (d !== 32'hBAAD_FACE || r !== 2'b10) begin
         errors++; $display("FAIL unmapped_read: got %h/%b, required baadface/10", d, r);
      end
      axi_write(9, 32'h1234_5678, 4'hF, resp);
      checks++;
      if (resp !== 2'b10 || cr_mix_channel_gain !== {UNITY, UNITY, 24'h01CDEF, UNITY}) begin
         errors++; $display("FAIL unmapped_write: got resp %b gains %h, required 10 and gains unchanged", resp, cr_mix_channel_gain);
      end
      axi_write(8, 32'hFF77_7777, 4'hF, resp);
      axi_read(8, d, r);
      checks++;
      if (resp !== 2'b00 || d !== 32'h0077_7777 || r !== 2'b00 || cr_mix_channel_gain[72 +: 24] !== 24'h777777) begin
         errors++; $display("FAIL last_channel: got bresp %b read %h/%b out %h, required 00 00777777/00 777777",
                            resp, d, r, cr_mix_channel_gain[72 +: 24]);
      end
   endtask

   task automatic test_irq();
      logic [1:0]  resp, r;
      logic [31:0] d;
      axi_write(3, 32'h0000_0005, 4'hF, resp);
      irq_set = 8'h07;
      @(posedge clk); #1;
      irq_set = 8'h00;
      @(negedge clk);
      checks++;
      if (irq !== 1'b0) begin
         errors++; $display("FAIL irq_lag: got irq %b one cycle after set, required 0", irq);
      end
      @(negedge clk);
      checks++;
      if (irq !== 1'b1) begin
         errors++; $display("FAIL irq_assert: got irq %b, required 1", irq);
      end
      @(posedge clk); #1;
      axi_read(2, d, r);
      checks++;
      if (d !== 32'h07 || r !== 2'b00) begin
         errors++; $display("FAIL status_set: got %h/%b, required 00000007/00", d, r);
      end
      awaddr = 16'(2 * 4); wdata = 32'h05; wstrb = 4'b0001; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      @(negedge clk);
      checks++;
      if ({awready, wready} !== 2'b11) begin
         errors++; $display("FAIL w1c_accept: got aw/w ready %b, required 11", {awready, wready});
      end
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; irq_set = 8'h01;
      @(posedge clk); #1;
      irq_set = 8'h00;
      @(negedge clk);
      checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || irq !== 1'b1) begin
         errors++; $display("FAIL w1c_bresp: got bvalid %b bresp %b irq %b, required 1 00 1", bvalid, bresp, irq);
      end
      @(posedge clk); #1;
      bready = 1'b0;
      axi_read(2, d, r);
      checks++;
      if (d !== 32'h03 || irq !== 1'b1) begin
         errors++; $display("FAIL status_set_wins: got status %h irq %b, required 00000003 1", d, irq);
      end
      axi_write(2, 32'h0000_0001, 4'b0001, resp);
      checks++;
      if (irq_at_b !== 1'b1) begin
         errors++; $display("FAIL irq_hold_at_commit: got irq %b in commit+1 cycle, required 1", irq_at_b);
      end
      @(negedge clk);
      checks++;
      if (irq !== 1'b0) begin
         errors++; $display("FAIL irq_clear: got irq %b, required 0", irq);
      end
      @(posedge clk); #1;
      axi_read(2, d, r);
      checks++;
      if (d !== 32'h02) begin
         errors++; $display("FAIL status_clear: got %h, required 00000002", d);
      end
   endtask

   task automatic test_read_hold();
      logic [1:0]  resp, r;
      logic [31:0] d;
      int          bad;
      bad = 0;
      axi_write(1, 32'h1122_3344, 4'hF, resp);
      awaddr = 16'(1 * 4); wdata = 32'hA5A5_A5A5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      araddr = 16'(1 * 4); arvalid = 1'b1; rready = 1'b0;
      @(negedge clk);
      checks++;
      if (arready !== 1'b1) begin
         errors++; $display("FAIL hold_ar_accept: got arready %b, required 1", arready);
      end
      @(posedge clk); #1;
      arvalid = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (rvalid !== 1'b1 || rdata !== 32'h1122_3344 || rresp !== 2'b00 || arready !== 1'b0) bad++;
         @(posedge clk); #1;
      end
      bready = 1'b0;
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL read_hold: got %0d unstable cycles (last rdata %h), required 0 with 11223344", bad, rdata);
      end
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
      axi_read(1, d, r);
      checks++;
      if (d !== 32'hA5A5_A5A5 || cr_led_0 !== 32'hA5A5_A5A5) begin
         errors++; $display("FAIL led_new: got read %h out %h, required a5a5a5a5", d, cr_led_0);
      end
      axi_write(1, 32'hFFFF_FFFF, 4'b1010, resp);
      checks++;
      if (cr_led_0 !== 32'hFFA5_FFA5) begin
         errors++; $display("FAIL led_strobe: got %h, required ffa5ffa5", cr_led_0);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] resp;
      logic       blocked_ok;
      blocked_ok = 1'b1;
      awaddr = 16'(1 * 4); wdata = 32'h0000_1111; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      wdata = 32'h2222_0000;
      repeat (5) begin
         @(negedge clk);
         if (awready !== 1'b0 || wready !== 1'b0) blocked_ok = 1'b0;
         @(posedge clk); #1;
      end
      @(negedge clk);
      checks++;
      if (blocked_ok !== 1'b1 || bvalid !== 1'b1 || bresp !== 2'b00 || cr_led_0 !== 32'h0000_1111) begin
         errors++; $display("FAIL b2b_block: got blocked_ok %b bvalid %b led %h, required 1 1 00001111",
                            blocked_ok, bvalid, cr_led_0);
      end
      @(posedge clk); #1;
      bready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0;
      axi_write(1, 32'h2222_0000, 4'hF, resp);
      checks++;
      if (resp !== 2'b00 || cr_led_0 !== 32'h2222_0000) begin
         errors++; $display("FAIL b2b_second: got resp %b led %h, required 00 22220000", resp, cr_led_0);
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0]  r;
      logic [31:0] d;
      int          bad;
      bad = 0;
      awaddr = 16'(4 * 4); wdata = 32'h0012_3456; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (bvalid !== 1'b1 || cr_mix_output_gain !== 24'h123456) begin
         errors++; $display("FAIL pre_reset: got bvalid %b gain %h, required 1 123456", bvalid, cr_mix_output_gain);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (bvalid !== 1'b0 || {awready, wready, arready, rvalid} !== 4'b0 || cr_mix_output_gain !== UNITY
          || cr_mix_channel_gain !== {4{UNITY}} || cr_led_0 !== 32'h0) begin
         errors++; $display("FAIL async_reset: got bvalid %b gain %h ch %h led %h, required 0 010000 all-010000 0",
                            bvalid, cr_mix_output_gain, cr_mix_channel_gain, cr_led_0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 4; i <= 8; i++) begin
         axi_read(i, d, r);
         if (d !== 32'h0001_0000 || r !== 2'b00) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL gains_after_reset: got %0d gain reads differing, required all 00010000", bad);
      end
   endtask

   initial begin
      test_reset();
      test_split_write();
      test_error_map();
      test_irq();
      test_read_hold();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
